// File: rtl/axis_wb_initiator.sv
// axis_wb_initiator: Wishbone classic slave that tunnels each access as a command
// packet over an AXI-Stream byte link and terminates it from the response packet.
module axis_wb_initiator #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [15:0]           wb_data_write,
  output logic [15:0]           wb_data_read,
  output logic                  wb_ack,
  output logic                  wb_err,
  input  logic                  m_axis_ready,
  output logic                  m_axis_valid,
  output logic [7:0]            m_axis_data,
  output logic                  s_axis_ready,
  input  logic                  s_axis_valid,
  input  logic [7:0]            s_axis_data,
  output logic                  timeout
);

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int TW         = $clog2(TIMEOUT + 2);
  localparam int TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_LAST_I);
  localparam logic [1:0]    ADDR_LAST = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_STATUS, S_RDATA, S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [1:0]            cnt_reg, cnt_next;
  logic                  abort_reg, abort_next;
  logic [TW-1:0]         tmo_cnt_reg, tmo_cnt_next;
  logic [7:0]            rx_hi_reg, rx_hi_next;
  logic                  m_valid_reg, m_valid_next;
  logic [7:0]            m_data_reg, m_data_next;
  logic                  s_ready_reg, s_ready_next;
  logic                  ack_reg, ack_next;
  logic                  err_reg, err_next;
  logic                  tmo_reg, tmo_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;

  logic [7:0] addr_bytes [4];
  logic       m_fire, s_fire, abort_now, tmo_hit;

  // Address bytes in transmit order (MSB first); unused slots read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_addr_byte
      if (gi < ADDR_BYTES) begin : g_used
        assign addr_bytes[gi] = addr_reg[(ADDR_BYTES-1-gi)*8 +: 8];
      end else begin : g_pad
        assign addr_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign m_fire    = m_valid_reg && m_axis_ready;
  assign s_fire    = s_axis_valid && s_ready_reg;
  assign abort_now = abort_reg || !wb_cyc;
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    state_next   = state_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    cnt_next     = cnt_reg;
    abort_next   = abort_reg;
    tmo_cnt_next = tmo_cnt_reg;
    rx_hi_next   = rx_hi_reg;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    rdata_next   = rdata_reg;
    ack_next     = 1'b0;
    err_next     = 1'b0;
    tmo_next     = 1'b0;

    // A master that gives up mid-packet is remembered so the terminator is dropped.
    if (state_reg != S_IDLE && !wb_cyc) begin
      abort_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        // A terminator still on the bus blocks a restart from a held strobe.
        if (wb_cyc && wb_stb && !ack_reg && !err_reg) begin
          we_next      = wb_we;
          addr_next    = wb_addr;
          wdata_next   = wb_data_write;
          abort_next   = 1'b0;
          m_valid_next = 1'b1;
          m_data_next  = {7'd0, wb_we};
          state_next   = S_CMD;
        end
      end
      S_CMD: begin
        if (m_fire) begin
          cnt_next    = 2'd0;
          m_data_next = addr_bytes[0];
          state_next  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_fire) begin
          if (cnt_reg != ADDR_LAST) begin
            cnt_next    = cnt_reg + 2'd1;
            m_data_next = addr_bytes[cnt_reg + 2'd1];
          end else if (we_reg) begin
            cnt_next    = 2'd0;
            m_data_next = wdata_reg[15:8];
            state_next  = S_WDATA;
          end else begin
            m_valid_next = 1'b0;
            m_data_next  = 8'h00;
            tmo_cnt_next = '0;
            state_next   = S_STATUS;
          end
        end
      end
      S_WDATA: begin
        if (m_fire) begin
          if (cnt_reg == 2'd0) begin
            cnt_next    = 2'd1;
            m_data_next = wdata_reg[7:0];
          end else begin
            m_valid_next = 1'b0;
            m_data_next  = 8'h00;
            tmo_cnt_next = '0;
            state_next   = S_STATUS;
          end
        end
      end
      S_STATUS: begin
        if (s_fire) begin
          tmo_cnt_next = '0;
          if (s_axis_data == 8'h00 && !we_reg) begin
            cnt_next   = 2'd0;
            state_next = S_RDATA;
          end else if (s_axis_data == 8'h00) begin
            ack_next   = !abort_now;
            state_next = S_DONE;
          end else begin
            err_next   = !abort_now;
            state_next = S_DONE;
          end
        end else if (tmo_hit) begin
          err_next   = !abort_now;
          tmo_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      S_RDATA: begin
        if (s_fire) begin
          tmo_cnt_next = '0;
          if (cnt_reg == 2'd0) begin
            rx_hi_next = s_axis_data;
            cnt_next   = 2'd1;
          end else begin
            if (!abort_now) begin
              rdata_next = {rx_hi_reg, s_axis_data};
            end
            ack_next   = !abort_now;
            state_next = S_DONE;
          end
        end else if (tmo_hit) begin
          err_next   = !abort_now;
          tmo_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    s_ready_next = (state_next == S_IDLE) || (state_next == S_STATUS) ||
                   (state_next == S_RDATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      cnt_reg     <= 2'd0;
      abort_reg   <= 1'b0;
      tmo_cnt_reg <= '0;
      rx_hi_reg   <= 8'h00;
      m_valid_reg <= 1'b0;
      m_data_reg  <= 8'h00;
      s_ready_reg <= 1'b0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      tmo_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      cnt_reg     <= cnt_next;
      abort_reg   <= abort_next;
      tmo_cnt_reg <= tmo_cnt_next;
      rx_hi_reg   <= rx_hi_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      s_ready_reg <= s_ready_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      tmo_reg     <= tmo_next;
      rdata_reg   <= rdata_next;
    end
  end

  assign m_axis_valid = m_valid_reg;
  assign m_axis_data  = m_data_reg;
  assign s_axis_ready = s_ready_reg;
  assign wb_ack       = ack_reg;
  assign wb_err       = err_reg;
  assign timeout      = tmo_reg;
  assign wb_data_read = rdata_reg;

endmodule

// File: tb/tb_axis_wb_initiator.sv
// Directed bench for axis_wb_initiator: drives Wishbone requests, captures the
// command byte stream, plays back response packets and checks the terminators.
module tb_axis_wb_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [15:0] wb_addr = 16'h0000, wb_data_write = 16'h0000;
  logic [15:0] wb_data_read;
  logic        wb_ack, wb_err;
  logic        m_axis_ready = 1'b0;
  logic        m_axis_valid;
  logic [7:0]  m_axis_data;
  logic        s_axis_ready;
  logic        s_axis_valid = 1'b0;
  logic [7:0]  s_axis_data = 8'h00;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  axis_wb_initiator #(.ADDR_WIDTH(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data_write(wb_data_write), .wb_data_read(wb_data_read),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .m_axis_ready(m_axis_ready), .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data),
    .s_axis_ready(s_axis_ready), .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_data_write = d;
  endtask

  // Collect n command bytes; optionally randomise ready and check hold-while-stalled.
  task automatic send_cmd(input int n, input bit rnd, output logic [63:0] bytes,
                          output int cycles);
    int   got;
    bit   stall;
    logic [7:0] held;
    logic r;
    got = 0; cycles = 0; stall = 0; held = 8'h00; bytes = '0;
    while (got < n && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (stall) begin
        check("hold_valid", m_axis_valid, 1);
        check("hold_data", m_axis_data, held);
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_ready = r;
      if (m_axis_valid && r) begin
        bytes = {bytes[55:0], m_axis_data};
        got++;
      end
      stall = m_axis_valid && !r;
      held  = m_axis_data;
    end
    check("cmd_byte_count", 64'(got), 64'(n));
  endtask

  task automatic give(input logic [7:0] b);
    @(negedge clk);
    check("s_ready_when_fed", s_axis_ready, 1);
    s_axis_valid = 1'b1; s_axis_data = b;
    @(posedge clk);
    #1 s_axis_valid = 1'b0;
  endtask

  task automatic end_term(input string tag, input logic exp_ack, input logic exp_err);
    @(negedge clk);
    $display("txn %-10s ack=%0d err=%0d tmo=%0d rdata=%h", tag, wb_ack, wb_err, timeout,
             wb_data_read);
    check({tag, "_ack"}, wb_ack, exp_ack);
    check({tag, "_err"}, wb_err, exp_err);
    check({tag, "_done_ready"}, s_axis_ready, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    check({tag, "_ack_pulse"}, wb_ack, 0);
    check({tag, "_err_pulse"}, wb_err, 0);
  endtask

  initial begin
    logic [63:0] bytes;
    int          cyc;
    int          k;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_m_valid", m_axis_valid, 0);
    check("rst_m_data", m_axis_data, 8'h00);
    check("rst_s_ready", s_axis_ready, 0);
    check("rst_ack", wb_ack, 0);
    check("rst_err", wb_err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rdata", wb_data_read, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", s_axis_ready, 1);

    // Write 0x1234 to 0xABCD at full rate
    start_req(1'b1, 16'hABCD, 16'h1234);
    send_cmd(5, 0, bytes, cyc);
    check("wr_bytes", bytes, 64'h01_AB_CD_12_34);
    check("wr_cycles", 64'(cyc), 64'd5);
    give(8'h00);
    end_term("write", 1, 0);

    // Read 0x0042 returning 0x5AA5
    start_req(1'b0, 16'h0042, 16'h0000);
    send_cmd(3, 0, bytes, cyc);
    check("rd_bytes", bytes, 64'h00_00_42);
    check("rd_cycles", 64'(cyc), 64'd3);
    give(8'h00); give(8'h5A); give(8'hA5);
    end_term("read", 1, 0);
    check("rd_data", wb_data_read, 16'h5AA5);

    // Error statuses: terminate with err, consume no data, keep read data
    start_req(1'b0, 16'h1111, 16'h0000);
    send_cmd(3, 0, bytes, cyc);
    check("err1_bytes", bytes, 64'h00_11_11);
    give(8'h01);
    end_term("rd_err01", 0, 1);
    start_req(1'b0, 16'h2222, 16'h0000);
    send_cmd(3, 0, bytes, cyc);
    give(8'h7F);
    end_term("rd_err7f", 0, 1);
    check("err_keeps_rdata", wb_data_read, 16'h5AA5);

    // Framing intact after errors
    start_req(1'b0, 16'h0100, 16'h0000);
    send_cmd(3, 0, bytes, cyc);
    give(8'h00); give(8'hC3); give(8'h3C);
    end_term("read2", 1, 0);
    check("rd2_data", wb_data_read, 16'hC33C);

    // Timeout with TIMEOUT=16: err+timeout 16 cycles after entering STATUS
    start_req(1'b1, 16'h0010, 16'hBEEF);
    send_cmd(5, 0, bytes, cyc);
    check("tmo_bytes", bytes, 64'h01_00_10_BE_EF);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (wb_err || timeout) break;
      k++;
    end
    $display("txn %-10s cycles=%0d err=%0d tmo=%0d", "timeout", k, wb_err, timeout);
    check("tmo_delay", 64'(k), 64'd16);
    check("tmo_err", wb_err, 1);
    check("tmo_pulse", timeout, 1);
    check("tmo_ack", wb_ack, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    check("tmo_err_pulse", wb_err, 0);
    check("tmo_pulse_width", timeout, 0);
    give(8'h00);
    @(negedge clk);
    check("late_byte_no_ack", wb_ack, 0);
    check("late_byte_no_tx", m_axis_valid, 0);
    start_req(1'b1, 16'h0002, 16'h0001);
    send_cmd(5, 0, bytes, cyc);
    check("post_tmo_bytes", bytes, 64'h01_00_02_00_01);
    give(8'h00);
    end_term("post_tmo", 1, 0);

    // Random ready during a write
    start_req(1'b1, 16'h55AA, 16'hC0DE);
    send_cmd(5, 1, bytes, cyc);
    check("rnd_bytes", bytes, 64'h01_55_AA_C0_DE);
    m_axis_ready = 1'b1;
    give(8'h00);
    end_term("rnd_write", 1, 0);

    // Reset while sending the address
    m_axis_ready = 1'b0;
    start_req(1'b0, 16'h7788, 16'h0000);
    @(negedge clk);
    m_axis_ready = 1'b1;
    @(negedge clk);
    check("addr_valid", m_axis_valid, 1);
    check("addr_byte0", m_axis_data, 8'h77);
    m_axis_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_axis_valid, 0);
    check("midrst_m_data", m_axis_data, 8'h00);
    check("midrst_s_ready", s_axis_ready, 0);
    check("midrst_rdata", wb_data_read, 16'h0000);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ack", wb_ack, 0);
    check("postrst_err", wb_err, 0);
    check("postrst_s_ready", s_axis_ready, 1);
    start_req(1'b0, 16'h00FF, 16'h0000);
    send_cmd(3, 0, bytes, cyc);
    check("postrst_bytes", bytes, 64'h00_00_FF);
    give(8'h00); give(8'h12); give(8'h34);
    end_term("postrst_rd", 1, 0);
    check("postrst_rdata", wb_data_read, 16'h1234);

    // Abort: cyc drops after latching; packet and response still run, no ack
    m_axis_ready = 1'b0;
    start_req(1'b1, 16'h2468, 16'h3579);
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    send_cmd(5, 0, bytes, cyc);
    check("abort_bytes", bytes, 64'h01_24_68_35_79);
    give(8'h00);
    end_term("abort", 0, 0);
    start_req(1'b0, 16'h0042, 16'h0000);
    send_cmd(3, 0, bytes, cyc);
    give(8'h00); give(8'h0F); give(8'hF0);
    end_term("post_abort", 1, 0);
    check("post_abort_rdata", wb_data_read, 16'h0FF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
